// File: rtl/multicycle_addsub_if.sv
// Handshake bundle for multicycle_addsub: operand side and result side.
interface multicycle_addsub_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cIn;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         Cout;
  logic         V;
  logic         Z;

  // Upstream/downstream view (testbench or surrounding logic).
  modport master (
    output in_valid, A, B, cIn, sub, out_ready,
    input  in_ready, out_valid, S, Cout, V, Z
  );

  // Arithmetic block view.
  modport slave (
    input  in_valid, A, B, cIn, sub, out_ready,
    output in_ready, out_valid, S, Cout, V, Z
  );
endinterface

// File: rtl/multicycle_addsub.sv
// N-bit add/subtract built from one CHUNK-bit ripple slice, iterated K = N/CHUNK times.
// Subtract is folded into the operands at accept time (Bx = ~B, c0 = cIn ^ sub), so the
// iteration itself is always a plain add with a carry carried between slices.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// BUSY  | adding slice idx_q each cycle, carry kept in carry_q
// DONE  | out_valid high, result and flags held until out_ready
module multicycle_addsub #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_addsub_if.slave  bus
);

  localparam int K  = N / CHUNK;
  localparam int IW = $clog2(K + 1);
  localparam int CW = CHUNK + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    bx_q;
  logic [N-1:0]    s_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic            cout_q;
  logic            v_q;
  logic            z_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [31:0]     base_d;
  logic [CHUNK-1:0] a_sl_d;
  logic [CHUNK-1:0] bx_sl_d;
  logic [CHUNK:0]  slice_d;
  logic [N-1:0]    s_d;
  logic            last_d;

  // Current slice add and the S value it produces; shifts avoid a wide index mux.
  always_comb begin
    base_d  = 32'(idx_q) * 32'(CHUNK);
    a_sl_d  = CHUNK'(a_q >> base_d);
    bx_sl_d = CHUNK'(bx_q >> base_d);
    slice_d = {1'b0, a_sl_d} + {1'b0, bx_sl_d} + CW'(carry_q);
    s_d     = (s_q & ~(N'({CHUNK{1'b1}}) << base_d))
            | (N'(slice_d[CHUNK-1:0]) << base_d);
    last_d  = (idx_q == IW'(K - 1));
  end

  // Control FSM with registered handshake outputs and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      bx_q        <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      cout_q      <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.A;
            bx_q       <= bus.sub ? ~bus.B : bus.B;
            carry_q    <= bus.cIn ^ bus.sub;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          s_q     <= s_d;
          carry_q <= slice_d[CHUNK];
          idx_q   <= idx_q + 1'b1;
          if (last_d) begin
            cout_q      <= slice_d[CHUNK];
            v_q         <= (a_q[N-1] == bx_q[N-1]) && (s_d[N-1] != a_q[N-1]);
            z_q         <= (s_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.V         = v_q;
  assign bus.Z         = z_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: four instances (CHUNK 1, 4, 8, 32; N = 32) share one
// stimulus stream and are checked against an arithmetic reference model.
module tb_multicycle_addsub;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        cIn = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;

  logic [NI-1:0]       ir_v, ov_v, c_v, v_v, z_v;
  logic [NI-1:0][31:0] s_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CH = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
    multicycle_addsub_if #(.N(32)) u_if ();
    multicycle_addsub #(.N(32), .CHUNK(CH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );
    assign u_if.in_valid  = in_valid;
    assign u_if.A         = A;
    assign u_if.B         = B;
    assign u_if.cIn       = cIn;
    assign u_if.sub       = sub;
    assign u_if.out_ready = out_ready;
    assign ir_v[g] = u_if.in_ready;
    assign ov_v[g] = u_if.out_valid;
    assign s_v[g]  = u_if.S;
    assign c_v[g]  = u_if.Cout;
    assign v_v[g]  = u_if.V;
    assign z_v[g]  = u_if.Z;
  end

  function automatic int chunk_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : (i == 2) ? 8 : 32;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, overflow from the true signed sum.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic s, output logic [31:0] es, output logic ec,
                       output logic ev, output logic ez);
    logic [31:0] bx;
    logic        c0;
    logic [32:0] full;
    longint      sr, hi, lo;
    bx   = s ? ~b : b;
    c0   = c ^ s;
    full = {1'b0, a} + {1'b0, bx} + {32'd0, c0};
    sr   = longint'($signed(a)) + longint'($signed(bx)) + longint'(c0);
    hi   = 2147483647;
    lo   = -hi - 1;
    es   = full[31:0];
    ec   = full[32];
    ev   = (sr > hi) || (sr < lo);
    ez   = (full[31:0] == 32'd0);
  endtask

  task automatic check_all(input string tag, input logic [31:0] es, input logic ec,
                           input logic ev, input logic ez);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_valid[ch%0d]", tag, chunk_of(i)), 64'(ov_v[i]), 64'd1);
      chk($sformatf("%s_S[ch%0d]", tag, chunk_of(i)), 64'(s_v[i]), 64'(es));
      chk($sformatf("%s_Cout[ch%0d]", tag, chunk_of(i)), 64'(c_v[i]), 64'(ec));
      chk($sformatf("%s_V[ch%0d]", tag, chunk_of(i)), 64'(v_v[i]), 64'(ev));
      chk($sformatf("%s_Z[ch%0d]", tag, chunk_of(i)), 64'(z_v[i]), 64'(ez));
    end
  endtask

  // Present one operand set for a single accepting edge, then scramble the inputs.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s);
    chk("in_ready_before_accept", 64'(ir_v), 64'hF);
    in_valid = 1'b1;
    A = a; B = b; cIn = c; sub = s;
    tick();
    in_valid = 1'b0;
    A = $urandom; B = $urandom; cIn = 1'($urandom); sub = 1'($urandom);
    chk("in_ready_after_accept", 64'(ir_v), 64'h0);
  endtask

  task automatic wait_all_valid();
    int n = 0;
    while (!(&ov_v) && n < 200) begin
      tick();
      n++;
    end
    chk("all_valid_within_bound", 64'(ov_v), 64'hF);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(ov_v), 64'h0);
    chk("in_ready_return", 64'(ir_v), 64'hF);
  endtask

  logic [31:0] d_a [6];
  logic [31:0] d_b [6];
  logic        d_c [6];
  logic        d_s [6];
  logic [31:0] d_es[6];
  logic        d_ec[6];
  logic        d_ev[6];
  logic        d_ez[6];

  initial begin
    logic [31:0] es, ra, rb;
    logic        ec, ev, ez, rc, rs, seen;

    // Expected results written out by hand.
    d_a[0] = 32'hFFFFFFFF; d_b[0] = 32'h1; d_c[0] = 0; d_s[0] = 0;
    d_es[0] = 32'h0;        d_ec[0] = 1; d_ev[0] = 0; d_ez[0] = 1;
    d_a[1] = 32'h7FFFFFFF; d_b[1] = 32'h1; d_c[1] = 0; d_s[1] = 0;
    d_es[1] = 32'h80000000; d_ec[1] = 0; d_ev[1] = 1; d_ez[1] = 0;
    d_a[2] = 32'h80000000; d_b[2] = 32'h1; d_c[2] = 0; d_s[2] = 1;
    d_es[2] = 32'h7FFFFFFF; d_ec[2] = 1; d_ev[2] = 1; d_ez[2] = 0;
    d_a[3] = 32'd5;        d_b[3] = 32'd7; d_c[3] = 0; d_s[3] = 1;
    d_es[3] = 32'hFFFFFFFE; d_ec[3] = 0; d_ev[3] = 0; d_ez[3] = 0;
    d_a[4] = 32'd5;        d_b[4] = 32'd7; d_c[4] = 1; d_s[4] = 1;
    d_es[4] = 32'hFFFFFFFD; d_ec[4] = 0; d_ev[4] = 0; d_ez[4] = 0;
    d_a[5] = 32'h00FFFFFF; d_b[5] = 32'h1; d_c[5] = 1; d_s[5] = 0;
    d_es[5] = 32'h01000001; d_ec[5] = 0; d_ev[5] = 0; d_ez[5] = 0;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(ir_v), 64'hF);
    chk("rst_out_valid", 64'(ov_v), 64'h0);
    chk("rst_S", 64'(s_v), 64'h0);
    chk("rst_Cout", 64'(c_v), 64'h0);
    chk("rst_V", 64'(v_v), 64'h0);
    chk("rst_Z", 64'(z_v), 64'h0);

    // Latency: CHUNK=8 valid on the 4th edge after accept, CHUNK=32 on the 1st.
    accept(d_a[0], d_b[0], d_c[0], d_s[0]);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("latency_ch8_edge%0d", k), 64'(ov_v[2]), 64'(k == 4));
      if (k == 1) chk("latency_ch32_edge1", 64'(ov_v[3]), 64'd1);
    end
    wait_all_valid();
    check_all("wrap", d_es[0], d_ec[0], d_ev[0], d_ez[0]);
    release_out();

    // Remaining directed vectors.
    for (int t = 1; t < 6; t++) begin
      accept(d_a[t], d_b[t], d_c[t], d_s[t]);
      wait_all_valid();
      check_all($sformatf("dir%0d", t), d_es[t], d_ec[t], d_ev[t], d_ez[t]);
      release_out();
    end

    // Backpressure: hold DONE for 10 cycles while the upstream keeps poking.
    accept(d_a[1], d_b[1], d_c[1], d_s[1]);
    wait_all_valid();
    for (int k = 0; k < 10; k++) begin
      in_valid = ~in_valid;
      A = $urandom; B = $urandom;
      tick();
      check_all($sformatf("hold%0d", k), d_es[1], d_ec[1], d_ev[1], d_ez[1]);
      chk($sformatf("hold_in_ready%0d", k), 64'(ir_v), 64'h0);
    end
    in_valid = 1'b0;
    release_out();

    // Reset two cycles after accept: aborted result must never appear.
    accept(d_a[0], d_b[0], d_c[0], d_s[0]);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 64'(ir_v), 64'hF);
    chk("midrst_out_valid", 64'(ov_v), 64'h0);
    chk("midrst_S", 64'(s_v), 64'h0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      seen = seen | (|ov_v);
    end
    chk("midrst_no_result", 64'(seen), 64'h0);
    chk("midrst_idle_ready", 64'(ir_v), 64'hF);

    // Random regression against the reference model.
    for (int n = 0; n < 1500; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: rb = ~ra;
        2: ra = 32'h80000000;
        3: rb = 32'h7FFFFFFF;
        default: ;
      endcase
      rc = 1'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rc, rs, es, ec, ev, ez);
      accept(ra, rb, rc, rs);
      wait_all_valid();
      check_all($sformatf("rnd%0d", n), es, ec, ev, ez);
      release_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
